// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-sharing multiplier controller: FSM states and
// the {ALUop2,ALUop1,ALUop0} operation selects of the attached ALU.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

endpackage

// File: rtl/alu_shift_add_mult_ctrl.sv
// Unsigned shift-add multiplier that borrows an external ALU as its adder, one iteration per clock.
// start accepted in IDLE only; done pulses WIDTH+1 cycles later; start in RUN/DONE is dropped, not queued.
module alu_shift_add_mult_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter logic [2:0]  OP_ADD = ALU_OP_ADD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [WIDTH-1:0]   alu_c,
    output logic [WIDTH-1:0]   alu_less,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [WIDTH-1:0]   alu_cout
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Only the top carry feeds the shift; the per-bit carries are not needed.
    logic unused_cout_lo;
    assign unused_cout_lo = ^alu_cout[WIDTH-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        alu_b = '0;
        case (state_q)
            RUN: begin
                busy  = 1'b1;
                alu_b = p_lo_q[0] ? m_q : '0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Product shift register: the ALU sum plus its carry forms the new upper
    // WIDTH+1 bits, and the whole {carry,sum,P_lo} vector shifts right by one.
    always_comb begin
        m_d    = m_q;
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d    = mcand;
                    p_hi_d = '0;
                    p_lo_d = mplier;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                p_hi_d = {alu_cout[WIDTH-1], alu_result[WIDTH-1:1]};
                p_lo_d = {alu_result[0], p_lo_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            cnt_q  <= '0;
        end else begin
            m_q    <= m_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign product  = {p_hi_q, p_lo_q};
    assign alu_a    = p_hi_q;
    assign alu_c    = '0;
    assign alu_less = '0;
    assign alu_op   = OP_ADD;

endmodule

// File: tb/tb_alu_shift_add_mult_ctrl.sv
// Directed bench for the shift-add multiplier with a behavioural 32-bit ALU attached.
module tb_alu_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand, mplier;
    logic        busy, done;
    logic [63:0] product;
    logic [31:0] alu_a, alu_b, alu_c, alu_less;
    logic [2:0]  alu_op;
    logic [31:0] alu_result, alu_cout;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_shift_add_mult_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    // Stand-in ALU: add when op selects add, per-bit carry-out vector.
    logic [32:0] sum33;
    logic [31:0] cin_vec;
    always_comb begin
        sum33      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = 32'h0;
        alu_cout   = 32'h0;
        cin_vec    = 32'h0;
        if (alu_op == 3'b010) begin
            alu_result = sum33[31:0];
            cin_vec    = alu_result ^ alu_a ^ alu_b;
            alu_cout   = (alu_a & alu_b) | ((alu_a ^ alu_b) & cin_vec);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Entered just after a falling edge; returns 1 time unit after the edge where done is seen.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit hold_start,
                            output int lat, output logic [63:0] prod, output int busy_bad);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_bad++;
        prod = product;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lat, busy_bad, cyc, dones, extra_busy;
        logic [63:0] prod;

        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,         32'h1234_5678, 64'h0};
        vecs[3] = '{32'd7,         32'd6,         64'h0000_0000_0000_002A};
        vecs[4] = '{32'd1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[7] = '{32'h1234_5678, 32'd0,         64'h0};

        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = 32'h0;
        mplier = 32'h0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        check("alu_op_add", alu_op, 3'b010);
        check("alu_c_zero", alu_c, 0);
        check("alu_less_zero", alu_less, 0);
        check("idle_alu_b", alu_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_mult(vecs[i].a, vecs[i].b, 1'b0, lat, prod, busy_bad);
            check($sformatf("v%0d_product", i), prod, vecs[i].exp);
            check($sformatf("v%0d_latency", i), lat, 33);
            check($sformatf("v%0d_busy_run", i), busy_bad, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold", i), product, vecs[i].exp);
            @(negedge clk);
        end

        // start pulses during RUN and DONE are ignored
        start = 1'b1; mcand = 32'd3; mplier = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 10) begin
                start = 1'b1; mcand = 32'd9; mplier = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("ign_latency", cyc, 33);
        check("ign_product", product, 64'hF);
        dones = done ? 1 : 0;
        start = 1'b1; mcand = 32'd100; mplier = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_done_start_busy", busy, 0);
        check("ign_done_start_product", product, 64'hF);
        extra_busy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) extra_busy++;
        end
        check("ign_single_done", dones, 1);
        check("ign_no_restart", extra_busy, 0);
        check("ign_product_held", product, 64'hF);
        @(negedge clk);

        // asynchronous reset at cycle 10 of RUN
        start = 1'b1; mcand = 32'hFFFF_FFFF; mplier = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_mult(32'd7, 32'd6, 1'b0, lat, prod, busy_bad);
        check("post_reset_product", prod, 64'd42);
        check("post_reset_latency", lat, 33);
        @(negedge clk);
        @(negedge clk);

        // start held high: second run accepted in IDLE one cycle after done
        run_mult(32'd3, 32'd5, 1'b1, lat, prod, busy_bad);
        check("b2b_first_product", prod, 64'hF);
        check("b2b_first_latency", lat, 33);
        mcand = 32'd7; mplier = 32'd6;
        @(posedge clk); #1;
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_held", product, 64'hF);
        @(posedge clk); #1;
        check("b2b_accept_busy", busy, 1);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("b2b_second_latency", lat, 33);
        check("b2b_second_product", product, 64'd42);
        @(posedge clk); #1;
        check("b2b_end_idle", busy, 0);
        check("b2b_end_held", product, 64'd42);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
